// File: rtl/element_readback_controller.sv
// Steps through stored element records one at a time: fetches each record,
// splits it into display fields, and advances on a go press-release.
module element_readback_controller #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              program_resetn,
    input  logic              start_readback,
    input  logic              go,
    input  logic              rewind,
    input  logic [ADDR_W:0]   element_count,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [31:0]       mem_rdata,
    output logic [2:0]        elem_type,
    output logic [9:0]        elem_value,
    output logic [3:0]        elem_exponent,
    output logic [3:0]        elem_node_a,
    output logic [3:0]        elem_node_b,
    output logic [ADDR_W-1:0] elem_index,
    output logic              elem_valid,
    output logic              end_readback,
    output logic [2:0]        current_state
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] FETCH     = 3'd1;
    localparam logic [2:0] WAIT_DATA = 3'd2;
    localparam logic [2:0] SHOW      = 3'd3;
    localparam logic [2:0] SHOW_WAIT = 3'd4;
    localparam logic [2:0] NEXT      = 3'd5;
    localparam logic [2:0] DONE      = 3'd6;

    localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE      = {{ADDR_W{1'b0}}, 1'b1};

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [ADDR_W-1:0] index;
    logic [ADDR_W-1:0] index_nxt;
    logic              armed;
    logic [ADDR_W:0]   eff_count;
    logic [ADDR_W:0]   index_plus_one;
    logic              last_elem;
    logic              count_zero;
    logic              unused_rdata_bits;

    assign eff_count      = (element_count > CAPACITY) ? CAPACITY : element_count;
    assign index_plus_one = {1'b0, index} + ONE;
    assign last_elem      = (index_plus_one >= eff_count);
    assign count_zero     = (element_count == '0);

    assign unused_rdata_bits = ^mem_rdata[31:25];

    always_comb begin
        state_nxt = state;
        index_nxt = index;
        if (rewind && (state != IDLE)) begin
            index_nxt = '0;
            state_nxt = count_zero ? DONE : FETCH;
        end else begin
            case (state)
                IDLE: begin
                    if (start_readback) begin
                        index_nxt = '0;
                        state_nxt = count_zero ? DONE : FETCH;
                    end
                end
                FETCH:     state_nxt = WAIT_DATA;
                WAIT_DATA: state_nxt = SHOW;
                SHOW: begin
                    if (go && armed) begin
                        state_nxt = SHOW_WAIT;
                    end
                end
                SHOW_WAIT: begin
                    if (!go) begin
                        state_nxt = NEXT;
                    end
                end
                NEXT: begin
                    if (last_elem) begin
                        state_nxt = DONE;
                    end else begin
                        index_nxt = index_plus_one[ADDR_W-1:0];
                        state_nxt = FETCH;
                    end
                end
                DONE: begin
                    if (!start_readback) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge program_resetn) begin
        if (!program_resetn) begin
            state <= IDLE;
            index <= '0;
        end else begin
            state <= state_nxt;
            index <= index_nxt;
        end
    end

    // A press only counts once go has been seen low after the previous one,
    // so a button still held when SHOW is entered cannot skip an element.
    always_ff @(posedge clk or negedge program_resetn) begin
        if (!program_resetn) begin
            armed <= 1'b0;
        end else if (state == SHOW) begin
            armed <= armed | ~go;
        end else begin
            armed <= ~go;
        end
    end

    always_ff @(posedge clk or negedge program_resetn) begin
        if (!program_resetn) begin
            elem_type     <= '0;
            elem_value    <= '0;
            elem_exponent <= '0;
            elem_node_a   <= '0;
            elem_node_b   <= '0;
        end else if (state == WAIT_DATA) begin
            elem_type     <= mem_rdata[2:0];
            elem_value    <= mem_rdata[12:3];
            elem_exponent <= mem_rdata[16:13];
            elem_node_a   <= mem_rdata[20:17];
            elem_node_b   <= mem_rdata[24:21];
        end
    end

    assign mem_addr      = index;
    assign mem_rd_en     = (state == FETCH);
    assign elem_index    = index;
    assign elem_valid    = (state == SHOW) || (state == SHOW_WAIT);
    assign end_readback  = (state == DONE);
    assign current_state = state;

endmodule
